fetch_pc_sequencer: RTL and testbench
=====================================

# fetch_pc_sequencer

Parametrised next-PC sequencer for fetch stage 1, generalising the fixed 4-wide next-PC/RAS control to `FETCH_WIDTH` slots. It owns the fetch PC register and resolves the redirect priority chain: recovery, exception, execute redirect, decode redirect, BTB/predictor taken slot, sequential. It generates RAS push/pop requests and adds two things the fixed version lacks: an I-cache miss wait state machine and a pending-redirect buffer for decode redirects that arrive while fetch is stalled. BTB, branch predictor, RAS and I-cache stay external; their lookup results are inputs.

## Interface

Parameters:
- `FETCH_WIDTH`, default 4: instruction slots per fetch bundle (1..8).
- `PC_WIDTH`, default 32: PC width in bits.
- `INST_BYTES`, default 8: byte stride between slots (power of 2).
- `RESET_PC`, default 0: PC value loaded on reset.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-low reset.
- `recover_valid_i` in 1, `recover_pc_i` in PC_WIDTH: global recovery (top priority).
- `exception_valid_i` in 1, `exception_pc_i` in PC_WIDTH: exception redirect.
- `ex_redirect_i` in 1, `ex_target_i` in PC_WIDTH: execute-stage indirect mispredict.
- `id_redirect_i` in 1, `id_target_i` in PC_WIDTH, `id_is_return_i` in 1: decode-stage redirect; a return uses `ras_top_cp_i`.
- `stall_i` in 1: downstream stall.
- `icache_miss_i` in 1, `fill_done_i` in 1: miss for the current PC; refill complete.
- `btb_hit_i` in FETCH_WIDTH, `btb_type_i` in 2*FETCH_WIDTH, `btb_target_i` in PC_WIDTH*FETCH_WIDTH, `pred_taken_i` in FETCH_WIDTH: per-slot lookup results, with slot i in field i.
- `ras_top_i` in PC_WIDTH, `ras_top_cp_i` in PC_WIDTH: speculative RAS top; checkpointed RAS top.
- `pc_o` out PC_WIDTH: current fetch PC.
- `pc_valid_o` out 1: the bundle at `pc_o` is valid this cycle.
- `ras_push_o` out 1, `ras_push_addr_o` out PC_WIDTH, `ras_pop_o` out 1: RAS requests.
- `taken_valid_o` out 1, `taken_slot_o` out $clog2(FETCH_WIDTH) (minimum 1 bit): the first effective taken slot.
- `redirect_pending_o` out 1: the pending buffer is occupied.

## Operation

- Branch types: 00 return, 01 call, 10 jump, 11 conditional.
- Slot i is effective-taken when `btb_hit[i] & (pred_taken[i] | type[i]!=11)`.
- The lowest effective-taken slot wins.
- Target of the winning slot: `ras_top_i` if its type is 00, otherwise `btb_target[i]`.
- Sequential next PC: `PC + FETCH_WIDTH*INST_BYTES`, wrapping modulo 2^PC_WIDTH. All adds wrap.
- `advance = (state==RUN) & ~stall_i & ~icache_miss_i`.
- Next-PC priority: recover > exception > EX redirect > pending/ID redirect > winning BTB slot > sequential.
  - Recover, exception and EX redirect apply at the next edge in any state and ignore stall.
  - Each of these clears the pending buffer and forces state to RUN.
- ID redirect rules:
  - Taken only when `advance`.
  - If not advancing, the target (`ras_top_cp_i` if `id_is_return_i`) is captured in the pending buffer.
  - A newer ID redirect overwrites an older pending one.
  - The pending entry applies on the first `advance` cycle, then clears.
  - When a pending entry exists and no fresh ID redirect arrives, BTB results are ignored for that cycle.
- RAS requests are asserted only when `advance`, the winning source is a BTB slot, and no higher redirect is present.
  - Type 01: `ras_push_o=1`, `ras_push_addr_o = PC + (slot+1)*INST_BYTES`.
  - Type 00: `ras_pop_o=1`.
  - Otherwise both are 0, and `ras_push_addr_o = PC`.
- Miss FSM:
  - RUN: on `icache_miss_i & ~stall_i`, go to MISS_WAIT; PC holds.
  - MISS_WAIT: on `fill_done_i`, go to REPLAY.
  - REPLAY: one cycle for the cache re-read, then RUN; PC holds.
- `pc_valid_o = (state==RUN) & ~icache_miss_i`.

## Timing

- Reset (`reset==0` at an edge): PC=RESET_PC, state=RUN, pending buffer empty.
  - Outputs after reset: `pc_o=RESET_PC`, `pc_valid_o=1` (when no miss), `ras_push_o=0`, `ras_pop_o=0`, `redirect_pending_o=0`.
  - Reset overrides every other input in the same cycle, including mid-miss.
- `taken_*`, `ras_*` and `pc_valid_o` are combinational from the registered PC and state plus the current inputs.
- `pc_o` updates one cycle after the selection.
- Redirect-to-fetch latency is 1 cycle.
- Miss penalty: the PC re-presents in REPLAY; `pc_valid_o` returns 1 on the cycle after REPLAY.
- Simultaneous events:
  - Recover plus ID redirect: recover wins and the pending buffer clears.
  - `fill_done_i` together with EX redirect: the redirect wins, state goes to RUN, and no REPLAY occurs.
  - `fill_done_i` in RUN is ignored.

## Structure

- Package `fetch_pkg` holds: the branch-type constants BR_RETURN, BR_CALL, BR_JUMP, BR_COND; the FSM state enum (RUN, MISS_WAIT, REPLAY); the redirect-source encoding.
- Sub-module `fetch_slot_select`: parametrised find-first over the effective-taken vector. It outputs valid, slot index, selected type and selected target.

## Test plan

- Sequential fetch, FETCH_WIDTH=4, INST_BYTES=8, RESET_PC=0x100, no hits: `pc_o` is 0x100, 0x120, 0x140. At PC=0xFFFFFFE0, `pc_o` wraps to 0x0.
- Slot 2 is a hit with type 01, target 0x4000, at PC=0x200 with stall low: `ras_push_o=1` and `ras_push_addr_o=0x218`. Next `pc_o` is 0x4000.
- Slot 1 is a not-predicted conditional and slot 3 is a return, with `ras_top_i=0x880`: `taken_slot_o=3` and `ras_pop_o=1`. Next `pc_o` is 0x880.
- Miss at PC=0x300: `pc_valid_o=0`. `fill_done_i` arrives 5 cycles later. REPLAY lasts 1 cycle, then `pc_valid_o=1` with `pc_o` still 0x300.
- ID redirect to 0x500 while `stall_i=1` for 3 cycles: `redirect_pending_o=1`, PC holds. On the first unstalled cycle `pc_o` becomes 0x500 and the pending flag clears. An EX redirect to 0x700 during the stall instead yields 0x700 and clears pending.
- Reset held low during MISS_WAIT: `pc_o=RESET_PC`, state is RUN, and no RAS requests are asserted.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch next-PC sequencer: branch-type codes, miss FSM
// states and the encoding of which source chose the next PC.
package fetch_pkg;

   localparam logic [1:0] BR_RETURN = 2'b00;
   localparam logic [1:0] BR_CALL   = 2'b01;
   localparam logic [1:0] BR_JUMP   = 2'b10;
   localparam logic [1:0] BR_COND   = 2'b11;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MISS_WAIT = 2'd1,
      REPLAY    = 2'd2
   } fetchState_e;

   typedef enum logic [2:0] {
      SRC_HOLD    = 3'd0,
      SRC_SEQ     = 3'd1,
      SRC_BTB     = 3'd2,
      SRC_PENDING = 3'd3,
      SRC_ID      = 3'd4,
      SRC_EX      = 3'd5,
      SRC_EXCEPT  = 3'd6,
      SRC_RECOVER = 3'd7
   } redirectSrc_e;

endpackage

// File: rtl/fetch_slot_select.sv
// Find-first over the per-slot effective-taken vector; the lowest slot wins.
module fetch_slot_select
   import fetch_pkg::*;
#(
   parameter int FETCH_WIDTH = 4,
   parameter int PC_WIDTH    = 32,
   parameter int SLOT_W      = 2
) (
   input  logic [FETCH_WIDTH-1:0]          btbHit,
   input  logic [2*FETCH_WIDTH-1:0]        btbType,
   input  logic [PC_WIDTH*FETCH_WIDTH-1:0] btbTarget,
   input  logic [FETCH_WIDTH-1:0]          predTaken,
   output logic                            selValid,
   output logic [SLOT_W-1:0]               selSlot,
   output logic [1:0]                      selType,
   output logic [PC_WIDTH-1:0]             selTarget
);

   always_comb begin
      selValid  = 1'b0;
      selSlot   = '0;
      selType   = BR_COND;
      selTarget = '0;
      // Scan downward so the lowest effective-taken slot is the last to write.
      for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
         if (btbHit[i] && (predTaken[i] || (btbType[2*i +: 2] != BR_COND))) begin
            selValid  = 1'b1;
            selSlot   = SLOT_W'(i);
            selType   = btbType[2*i +: 2];
            selTarget = btbTarget[PC_WIDTH*i +: PC_WIDTH];
         end
      end
   end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage-1 next-PC sequencer: redirect priority chain, RAS requests,
// I-cache miss wait FSM and a one-entry buffer for stalled decode redirects.
module fetch_pc_sequencer
   import fetch_pkg::*;
#(
   parameter int          FETCH_WIDTH = 4,
   parameter int          PC_WIDTH    = 32,
   parameter int          INST_BYTES  = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   localparam int         SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            recover_valid_i,
   input  logic [PC_WIDTH-1:0]             recover_pc_i,
   input  logic                            exception_valid_i,
   input  logic [PC_WIDTH-1:0]             exception_pc_i,
   input  logic                            ex_redirect_i,
   input  logic [PC_WIDTH-1:0]             ex_target_i,
   input  logic                            id_redirect_i,
   input  logic [PC_WIDTH-1:0]             id_target_i,
   input  logic                            id_is_return_i,
   input  logic                            stall_i,
   input  logic                            icache_miss_i,
   input  logic                            fill_done_i,
   input  logic [FETCH_WIDTH-1:0]          btb_hit_i,
   input  logic [2*FETCH_WIDTH-1:0]        btb_type_i,
   input  logic [PC_WIDTH*FETCH_WIDTH-1:0] btb_target_i,
   input  logic [FETCH_WIDTH-1:0]          pred_taken_i,
   input  logic [PC_WIDTH-1:0]             ras_top_i,
   input  logic [PC_WIDTH-1:0]             ras_top_cp_i,
   output logic [PC_WIDTH-1:0]             pc_o,
   output logic                            pc_valid_o,
   output logic                            ras_push_o,
   output logic [PC_WIDTH-1:0]             ras_push_addr_o,
   output logic                            ras_pop_o,
   output logic                            taken_valid_o,
   output logic [SLOT_W-1:0]               taken_slot_o,
   output logic                            redirect_pending_o
);

   localparam logic [PC_WIDTH-1:0] BUNDLE_STRIDE = PC_WIDTH'(FETCH_WIDTH * INST_BYTES);
   localparam logic [PC_WIDTH-1:0] SLOT_STRIDE   = PC_WIDTH'(INST_BYTES);

   fetchState_e         state, stateNext;
   redirectSrc_e        nextSrc;
   logic [PC_WIDTH-1:0] pc, pcNext, pendPc, idTarget, btbPc;
   logic                pendValid, advance, hiRedirect, btbWins;
   logic                selValid;
   logic [SLOT_W-1:0]   selSlot;
   logic [1:0]          selType;
   logic [PC_WIDTH-1:0] selTarget;

   fetch_slot_select #(
      .FETCH_WIDTH(FETCH_WIDTH),
      .PC_WIDTH   (PC_WIDTH),
      .SLOT_W     (SLOT_W)
   ) slotSelect (
      .btbHit   (btb_hit_i),
      .btbType  (btb_type_i),
      .btbTarget(btb_target_i),
      .predTaken(pred_taken_i),
      .selValid (selValid),
      .selSlot  (selSlot),
      .selType  (selType),
      .selTarget(selTarget)
   );

   assign advance    = (state == RUN) && !stall_i && !icache_miss_i;
   assign hiRedirect = recover_valid_i || exception_valid_i || ex_redirect_i;
   assign idTarget   = id_is_return_i ? ras_top_cp_i : id_target_i;
   assign btbPc      = (selType == BR_RETURN) ? ras_top_i : selTarget;
   // A pending decode redirect masks the BTB for the cycle it drains.
   assign btbWins    = advance && !hiRedirect && !id_redirect_i && !pendValid && selValid;

   always_comb begin
      nextSrc = SRC_HOLD;
      if (recover_valid_i)        nextSrc = SRC_RECOVER;
      else if (exception_valid_i) nextSrc = SRC_EXCEPT;
      else if (ex_redirect_i)     nextSrc = SRC_EX;
      else if (advance) begin
         if (id_redirect_i)       nextSrc = SRC_ID;
         else if (pendValid)      nextSrc = SRC_PENDING;
         else if (selValid)       nextSrc = SRC_BTB;
         else                     nextSrc = SRC_SEQ;
      end
   end

   always_comb begin
      pcNext = pc;
      case (nextSrc)
         SRC_RECOVER: pcNext = recover_pc_i;
         SRC_EXCEPT:  pcNext = exception_pc_i;
         SRC_EX:      pcNext = ex_target_i;
         SRC_ID:      pcNext = idTarget;
         SRC_PENDING: pcNext = pendPc;
         SRC_BTB:     pcNext = btbPc;
         SRC_SEQ:     pcNext = pc + BUNDLE_STRIDE;
         default:     pcNext = pc;
      endcase
   end

   always_comb begin
      stateNext = state;
      if (hiRedirect) stateNext = RUN;
      else begin
         case (state)
            RUN:       if (icache_miss_i && !stall_i) stateNext = MISS_WAIT;
            MISS_WAIT: if (fill_done_i) stateNext = REPLAY;
            REPLAY:    stateNext = RUN;
            default:   stateNext = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc        <= RESET_PC;
         state     <= RUN;
         pendValid <= 1'b0;
         pendPc    <= '0;
      end else begin
         pc    <= pcNext;
         state <= stateNext;
         if (hiRedirect || advance) pendValid <= 1'b0;
         else if (id_redirect_i) begin
            pendValid <= 1'b1;
            pendPc    <= idTarget;
         end
      end
   end

   assign pc_o               = pc;
   assign pc_valid_o         = (state == RUN) && !icache_miss_i;
   assign ras_push_o         = btbWins && (selType == BR_CALL);
   assign ras_pop_o          = btbWins && (selType == BR_RETURN);
   assign ras_push_addr_o    = ras_push_o ? pc + (PC_WIDTH'(selSlot) + PC_WIDTH'(1)) * SLOT_STRIDE : pc;
   assign taken_valid_o      = selValid;
   assign taken_slot_o       = selSlot;
   assign redirect_pending_o = pendValid;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer at FETCH_WIDTH=4, INST_BYTES=8, RESET_PC=0x100.
module tb_fetch_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        recover_valid_i = 0, exception_valid_i = 0, ex_redirect_i = 0;
   logic [31:0] recover_pc_i = 0, exception_pc_i = 0, ex_target_i = 0;
   logic        id_redirect_i = 0, id_is_return_i = 0, stall_i = 0;
   logic [31:0] id_target_i = 0;
   logic        icache_miss_i = 0, fill_done_i = 0;
   logic [3:0]  btb_hit_i = 0, pred_taken_i = 0;
   logic [7:0]  btb_type_i = 0;
   logic [127:0] btb_target_i = 0;
   logic [31:0] ras_top_i = 0, ras_top_cp_i = 0;
   logic [31:0] pc_o, ras_push_addr_o;
   logic        pc_valid_o, ras_push_o, ras_pop_o, taken_valid_o, redirect_pending_o;
   logic [1:0]  taken_slot_o;

   int checks = 0;
   int failures = 0;

   fetch_pc_sequencer #(
      .FETCH_WIDTH(4), .PC_WIDTH(32), .INST_BYTES(8), .RESET_PC(32'h100)
   ) dut (
      .clk(clk), .reset(reset),
      .recover_valid_i(recover_valid_i), .recover_pc_i(recover_pc_i),
      .exception_valid_i(exception_valid_i), .exception_pc_i(exception_pc_i),
      .ex_redirect_i(ex_redirect_i), .ex_target_i(ex_target_i),
      .id_redirect_i(id_redirect_i), .id_target_i(id_target_i), .id_is_return_i(id_is_return_i),
      .stall_i(stall_i), .icache_miss_i(icache_miss_i), .fill_done_i(fill_done_i),
      .btb_hit_i(btb_hit_i), .btb_type_i(btb_type_i), .btb_target_i(btb_target_i),
      .pred_taken_i(pred_taken_i), .ras_top_i(ras_top_i), .ras_top_cp_i(ras_top_cp_i),
      .pc_o(pc_o), .pc_valid_o(pc_valid_o), .ras_push_o(ras_push_o),
      .ras_push_addr_o(ras_push_addr_o), .ras_pop_o(ras_pop_o),
      .taken_valid_o(taken_valid_o), .taken_slot_o(taken_slot_o),
      .redirect_pending_o(redirect_pending_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pc(input logic [31:0] addr);
      recover_valid_i = 1'b1;
      recover_pc_i    = addr;
      step();
      recover_valid_i = 1'b0;
      #1;
   endtask

   task automatic clear_btb();
      btb_hit_i = 0; btb_type_i = 0; btb_target_i = 0; pred_taken_i = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step(); step();
      checks++; if (pc_o !== 32'h100) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h100); end
      checks++; if (pc_valid_o !== 1'b1) begin failures++; $display("FAIL reset_valid got=%b exp=1", pc_valid_o); end
      checks++; if ({ras_push_o, ras_pop_o} !== 2'b00) begin failures++; $display("FAIL reset_ras got=%b exp=00", {ras_push_o, ras_pop_o}); end
      checks++; if (redirect_pending_o !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", redirect_pending_o); end
      reset = 1'b1;
      #1;
   endtask

   task automatic test_sequential();
      checks++; if (pc_o !== 32'h100) begin failures++; $display("FAIL seq0 got=%h exp=%h", pc_o, 32'h100); end
      step();
      checks++; if (pc_o !== 32'h120) begin failures++; $display("FAIL seq1 got=%h exp=%h", pc_o, 32'h120); end
      step();
      checks++; if (pc_o !== 32'h140) begin failures++; $display("FAIL seq2 got=%h exp=%h", pc_o, 32'h140); end
      set_pc(32'hFFFF_FFE0);
      checks++; if (pc_o !== 32'hFFFF_FFE0) begin failures++; $display("FAIL recover_pc got=%h exp=%h", pc_o, 32'hFFFF_FFE0); end
      step();
      checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL seq_wrap got=%h exp=0", pc_o); end
   endtask

   task automatic test_call();
      set_pc(32'h200);
      btb_hit_i = 4'b0100;
      btb_type_i[5:4] = 2'b01;
      btb_target_i[95:64] = 32'h4000;
      #1;
      checks++; if (ras_push_o !== 1'b1) begin failures++; $display("FAIL call_push got=%b exp=1", ras_push_o); end
      checks++; if (ras_push_addr_o !== 32'h218) begin failures++; $display("FAIL call_addr got=%h exp=%h", ras_push_addr_o, 32'h218); end
      checks++; if ({taken_valid_o, taken_slot_o} !== 3'b110) begin failures++; $display("FAIL call_slot got=%b exp=110", {taken_valid_o, taken_slot_o}); end
      checks++; if (ras_pop_o !== 1'b0) begin failures++; $display("FAIL call_pop got=%b exp=0", ras_pop_o); end
      step();
      clear_btb();
      #1;
      checks++; if (pc_o !== 32'h4000) begin failures++; $display("FAIL call_target got=%h exp=%h", pc_o, 32'h4000); end
   endtask

   task automatic test_return();
      btb_hit_i = 4'b1010;
      btb_type_i[3:2] = 2'b11;
      btb_type_i[7:6] = 2'b00;
      btb_target_i[63:32] = 32'h1234;
      btb_target_i[127:96] = 32'h5678;
      ras_top_i = 32'h880;
      #1;
      checks++; if ({taken_valid_o, taken_slot_o} !== 3'b111) begin failures++; $display("FAIL ret_slot got=%b exp=111", {taken_valid_o, taken_slot_o}); end
      checks++; if ({ras_pop_o, ras_push_o} !== 2'b10) begin failures++; $display("FAIL ret_ras got=%b exp=10", {ras_pop_o, ras_push_o}); end
      checks++; if (ras_push_addr_o !== 32'h4000) begin failures++; $display("FAIL ret_addr got=%h exp=%h", ras_push_addr_o, 32'h4000); end
      step();
      clear_btb();
      #1;
      checks++; if (pc_o !== 32'h880) begin failures++; $display("FAIL ret_target got=%h exp=%h", pc_o, 32'h880); end
   endtask

   task automatic test_miss();
      set_pc(32'h300);
      icache_miss_i = 1'b1;
      #1;
      checks++; if (pc_valid_o !== 1'b0) begin failures++; $display("FAIL miss_valid got=%b exp=0", pc_valid_o); end
      step();
      icache_miss_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if ({pc_valid_o, pc_o} !== {1'b0, 32'h300}) begin failures++; $display("FAIL miss_wait%0d got=%b/%h exp=0/300", i, pc_valid_o, pc_o); end
         step();
      end
      fill_done_i = 1'b1;
      step();
      fill_done_i = 1'b0;
      #1;
      checks++; if ({pc_valid_o, pc_o} !== {1'b0, 32'h300}) begin failures++; $display("FAIL replay got=%b/%h exp=0/300", pc_valid_o, pc_o); end
      step();
      checks++; if ({pc_valid_o, pc_o} !== {1'b1, 32'h300}) begin failures++; $display("FAIL after_replay got=%b/%h exp=1/300", pc_valid_o, pc_o); end
   endtask

   task automatic test_pending();
      stall_i = 1'b1;
      id_redirect_i = 1'b1;
      id_target_i = 32'h500;
      step();
      id_redirect_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if ({redirect_pending_o, pc_o} !== {1'b1, 32'h300}) begin failures++; $display("FAIL pend_hold%0d got=%b/%h exp=1/300", i, redirect_pending_o, pc_o); end
         step();
      end
      stall_i = 1'b0;
      btb_hit_i = 4'b0001;
      btb_type_i[1:0] = 2'b01;
      btb_target_i[31:0] = 32'h4444;
      #1;
      checks++; if (ras_push_o !== 1'b0) begin failures++; $display("FAIL pend_masks_btb got=%b exp=0", ras_push_o); end
      step();
      clear_btb();
      #1;
      checks++; if ({redirect_pending_o, pc_o} !== {1'b0, 32'h500}) begin failures++; $display("FAIL pend_apply got=%b/%h exp=0/500", redirect_pending_o, pc_o); end
   endtask

   task automatic test_ex_over_pending();
      stall_i = 1'b1;
      id_redirect_i = 1'b1;
      id_target_i = 32'h600;
      step();
      id_redirect_i = 1'b0;
      #1;
      checks++; if (redirect_pending_o !== 1'b1) begin failures++; $display("FAIL ex_pend_set got=%b exp=1", redirect_pending_o); end
      ex_redirect_i = 1'b1;
      ex_target_i = 32'h700;
      step();
      ex_redirect_i = 1'b0;
      #1;
      checks++; if ({redirect_pending_o, pc_o} !== {1'b0, 32'h700}) begin failures++; $display("FAIL ex_over_pend got=%b/%h exp=0/700", redirect_pending_o, pc_o); end
      stall_i = 1'b0;
      step();
      checks++; if (pc_o !== 32'h720) begin failures++; $display("FAIL ex_then_seq got=%h exp=%h", pc_o, 32'h720); end
   endtask

   task automatic test_back_to_back();
      stall_i = 1'b1;
      recover_valid_i = 1'b1; recover_pc_i = 32'h900;
      id_redirect_i = 1'b1; id_target_i = 32'hA00;
      step();
      recover_valid_i = 1'b0; id_redirect_i = 1'b0; stall_i = 1'b0;
      #1;
      checks++; if ({redirect_pending_o, pc_o} !== {1'b0, 32'h900}) begin failures++; $display("FAIL recover_vs_id got=%b/%h exp=0/900", redirect_pending_o, pc_o); end
      icache_miss_i = 1'b1;
      step();
      icache_miss_i = 1'b0;
      fill_done_i = 1'b1; ex_redirect_i = 1'b1; ex_target_i = 32'hB00;
      step();
      fill_done_i = 1'b0; ex_redirect_i = 1'b0;
      #1;
      checks++; if ({pc_valid_o, pc_o} !== {1'b1, 32'hB00}) begin failures++; $display("FAIL fill_ex got=%b/%h exp=1/b00", pc_valid_o, pc_o); end
      step();
      checks++; if (pc_o !== 32'hB20) begin failures++; $display("FAIL fill_ex_noreplay got=%h exp=%h", pc_o, 32'hB20); end
      id_redirect_i = 1'b1; id_is_return_i = 1'b1; id_target_i = 32'hDEAD0; ras_top_cp_i = 32'hC40;
      step();
      id_redirect_i = 1'b0; id_is_return_i = 1'b0;
      fill_done_i = 1'b1;
      #1;
      checks++; if (pc_o !== 32'hC40) begin failures++; $display("FAIL id_return got=%h exp=%h", pc_o, 32'hC40); end
      step();
      fill_done_i = 1'b0;
      #1;
      checks++; if ({pc_valid_o, pc_o} !== {1'b1, 32'hC60}) begin failures++; $display("FAIL fill_in_run got=%b/%h exp=1/c60", pc_valid_o, pc_o); end
   endtask

   task automatic test_reset_mid_miss();
      icache_miss_i = 1'b1;
      step();
      icache_miss_i = 1'b0;
      step();
      checks++; if (pc_valid_o !== 1'b0) begin failures++; $display("FAIL rstmiss_wait got=%b exp=0", pc_valid_o); end
      reset = 1'b0;
      fill_done_i = 1'b1;
      step();
      fill_done_i = 1'b0;
      #1;
      checks++; if ({pc_valid_o, pc_o} !== {1'b1, 32'h100}) begin failures++; $display("FAIL rstmiss_pc got=%b/%h exp=1/100", pc_valid_o, pc_o); end
      checks++; if ({ras_push_o, ras_pop_o, redirect_pending_o} !== 3'b000) begin failures++; $display("FAIL rstmiss_ras got=%b exp=000", {ras_push_o, ras_pop_o, redirect_pending_o}); end
      reset = 1'b1;
      step();
      checks++; if (pc_o !== 32'h120) begin failures++; $display("FAIL rstmiss_run got=%h exp=%h", pc_o, 32'h120); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_call();
      test_return();
      test_miss();
      test_pending();
      test_ex_over_pending();
      test_back_to_back();
      test_reset_mid_miss();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
